// File: rtl/scroll_controller.sv
// Road scroll, race distance/time and finish-line tracking, all advanced once per video frame.
// Sub-pixel motion is carried in a 6-bit fraction so slow speeds still move the road over several frames.
module scroll_controller #(
    parameter logic [15:0] TRACK_LENGTH = 16'd20000,
    parameter logic [10:0] PLAYER_Y     = 11'd380,
    parameter logic [10:0] SCREEN_H     = 11'd480
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        frame_start,
    input  logic [9:0]  player_speed,
    input  logic        restart,
    output logic [10:0] scroll_y,
    output logic [15:0] distance,
    output logic        finish_active,
    output logic [10:0] finish_y,
    output logic        finished,
    output logic [15:0] elapsed_frames,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        RACING   = 2'd0,
        APPROACH = 2'd1,
        FINISHED = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  frac;

    logic [9:0]  speed_c;
    logic [9:0]  sum;
    logic [3:0]  step;
    logic [11:0] scroll_sum;
    logic [10:0] scroll_next;
    logic [16:0] dist_sum;
    logic [15:0] dist_next;
    logic [15:0] remaining;
    logic [11:0] fy_sum;
    logic [15:0] el_next;

    always_comb begin
        speed_c     = (player_speed > 10'd512) ? 10'd512 : player_speed;
        sum         = {4'd0, frac} + speed_c;
        step        = sum[9:6];
        scroll_sum  = {1'b0, scroll_y} + {8'd0, step};
        scroll_next = (scroll_sum >= {1'b0, SCREEN_H}) ? 11'(scroll_sum - {1'b0, SCREEN_H})
                                                       : scroll_sum[10:0];
        dist_sum    = {1'b0, distance} + {13'd0, step};
        dist_next   = (dist_sum >= {1'b0, TRACK_LENGTH}) ? TRACK_LENGTH : dist_sum[15:0];
        remaining   = TRACK_LENGTH - dist_next;
        fy_sum      = {1'b0, finish_y} + {8'd0, step};
        el_next     = (elapsed_frames == 16'hFFFF) ? 16'hFFFF : elapsed_frames + 16'd1;
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= RACING;
            frac           <= 6'd0;
            scroll_y       <= 11'd0;
            distance       <= 16'd0;
            finish_active  <= 1'b0;
            finish_y       <= 11'd0;
            finished       <= 1'b0;
            elapsed_frames <= 16'd0;
        end else if (restart) begin
            // scroll_y deliberately keeps its value so the road does not jump on restart
            state          <= RACING;
            frac           <= 6'd0;
            distance       <= 16'd0;
            finish_active  <= 1'b0;
            finish_y       <= 11'd0;
            finished       <= 1'b0;
            elapsed_frames <= 16'd0;
        end else if (frame_start) begin
            frac     <= sum[5:0];
            scroll_y <= scroll_next;
            case (state)
                RACING, APPROACH: begin
                    distance       <= dist_next;
                    elapsed_frames <= el_next;
                    if (remaining == 16'd0) begin
                        state         <= FINISHED;
                        finished      <= 1'b1;
                        finish_active <= 1'b1;
                        finish_y      <= PLAYER_Y;
                    end else if (remaining <= {5'd0, PLAYER_Y}) begin
                        state         <= APPROACH;
                        finish_active <= 1'b1;
                        finish_y      <= PLAYER_Y - remaining[10:0];
                    end
                end
                FINISHED: begin
                    // line scrolls down past the car; once off-screen its row is left frozen
                    if (finish_active) begin
                        if (fy_sum >= {1'b0, SCREEN_H}) begin
                            finish_active <= 1'b0;
                        end else begin
                            finish_y <= fy_sum[10:0];
                        end
                    end
                end
                default: state <= RACING;
            endcase
        end
    end

endmodule
